// File: rtl/rx_pkg.sv
// Shared types and defaults for the RX byte-to-word packer: write-FSM states,
// default parameter values and the byte-index to lane mapping.
package rx_pkg;

  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int ERR_CNT_W_DEF      = 16;
  localparam int MSB_FIRST_DEF      = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2
  } wr_state_e;

  // Lane that the byte at position idx of a word lands in.
  function automatic int lane_of(input int idx, input int nbytes, input int msb_first);
    return (msb_first != 0) ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/rx_word_packer_if.sv
// Byte-side and FIFO-side signal bundle of rx_word_packer; slave is the packer,
// master is whatever drives the bytes and owns the FIFO.
interface rx_word_packer_if
  import rx_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int ERR_CNT_W      = ERR_CNT_W_DEF
);

  logic [7:0]                  data_in;
  logic                        data_valid;
  logic                        parity_in;
  logic                        flush;
  logic                        clr_cnt;
  logic                        fifo_full;
  logic                        fifo_wr_success;
  logic                        fifo_wr_en;
  logic [8*BYTES_PER_WORD-1:0] word_out;
  logic                        byte_toggle;
  logic                        word_toggle;
  logic [ERR_CNT_W-1:0]        par_err_cnt;
  logic [ERR_CNT_W-1:0]        ovr_cnt;
  logic                        irq;

  modport master (
    output data_in, data_valid, parity_in, flush, clr_cnt, fifo_full, fifo_wr_success,
    input  fifo_wr_en, word_out, byte_toggle, word_toggle, par_err_cnt, ovr_cnt, irq
  );

  modport slave (
    input  data_in, data_valid, parity_in, flush, clr_cnt, fifo_full, fifo_wr_success,
    output fifo_wr_en, word_out, byte_toggle, word_toggle, par_err_cnt, ovr_cnt, irq
  );

endinterface

// File: rtl/rx_fifo_wr_ctrl.sv
// Write handshake for the one-entry holding register: one fifo_wr_en pulse per
// held word, then wait for the FIFO acknowledge before freeing the entry.
module rx_fifo_wr_ctrl
  import rx_pkg::*;
(
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic hold_vld,
  input  logic fifo_full,
  input  logic fifo_wr_success,
  output logic fifo_wr_en,
  output logic hold_release
);

  wr_state_e state_q;
  wr_state_e state_d;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An acknowledge outside WAIT_ACK falls through the case untouched.
  always_comb begin
    state_d      = state_q;
    fifo_wr_en   = 1'b0;
    hold_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_vld && !fifo_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        fifo_wr_en = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (fifo_wr_success) begin
          hold_release = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs received bytes into BYTES_PER_WORD-byte words and hands them to a FIFO.
// Optional build macro RX_PARITY_CHECK_EN enables even-parity error counting.
module rx_word_packer
  import rx_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int ERR_CNT_W      = ERR_CNT_W_DEF,
  parameter int MSB_FIRST      = MSB_FIRST_DEF
) (
  input logic             s_axi_aclk,
  input logic             s_axi_aresetn,
  rx_word_packer_if.slave bus
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [IDX_W-1:0]     idx_q;
  logic [WORD_W-1:0]    word_q;
  logic [WORD_W-1:0]    word_next;
  logic [WORD_W-1:0]    hold_q;
  logic                 hold_vld_q;
  logic                 byte_tgl_q;
  logic                 word_tgl_q;
  logic                 irq_q;
  logic [ERR_CNT_W-1:0] ovr_cnt_q;

  logic accept;
  logic complete;
  logic hold_free;
  logic load;
  logic ovr_event;
  logic ovr_inc;
  logic hold_release;
  logic wr_en;

  // Flush wins over a coincident byte strobe.
  assign accept    = bus.data_valid & ~bus.flush;
  assign complete  = accept & (idx_q == LAST_IDX);
  assign hold_free = ~hold_vld_q | hold_release;
  assign load      = complete & hold_free;
  assign ovr_event = complete & ~hold_free;
  assign ovr_inc   = ovr_event & ~bus.clr_cnt & ~(&ovr_cnt_q);

  always_comb begin
    word_next = word_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane_of(int'(idx_q), BYTES_PER_WORD, MSB_FIRST) == i) begin
        word_next[i*8 +: 8] = bus.data_in;
      end
    end
  end

  // Byte stage: index and toggle; stale lanes are simply overwritten after a flush.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      idx_q      <= '0;
      byte_tgl_q <= 1'b0;
    end else if (bus.flush) begin
      idx_q <= '0;
    end else if (accept) begin
      byte_tgl_q <= ~byte_tgl_q;
      idx_q      <= complete ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (accept) begin
      word_q <= word_next;
    end
  end

  // Word stage: holding register, overrun accounting and interrupt.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      word_tgl_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      if (load) begin
        hold_q     <= word_next;
        hold_vld_q <= 1'b1;
      end else if (hold_release) begin
        hold_vld_q <= 1'b0;
      end
      if (complete) begin
        word_tgl_q <= ~word_tgl_q;
      end
      irq_q <= hold_release | ovr_inc;
      if (bus.clr_cnt) begin
        ovr_cnt_q <= '0;
      end else if (ovr_event) begin
        ovr_cnt_q <= sat_inc(ovr_cnt_q);
      end
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic [ERR_CNT_W-1:0] par_cnt_q;
  logic                 par_err;

  assign par_err = accept & (^{bus.data_in, bus.parity_in});

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      par_cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      par_cnt_q <= '0;
    end else if (par_err) begin
      par_cnt_q <= sat_inc(par_cnt_q);
    end
  end

  assign bus.par_err_cnt = par_cnt_q;
`else
  logic unused_parity;
  assign unused_parity   = bus.parity_in;
  assign bus.par_err_cnt = '0;
`endif

  rx_fifo_wr_ctrl u_wr_ctrl (
    .s_axi_aclk      (s_axi_aclk),
    .s_axi_aresetn   (s_axi_aresetn),
    .hold_vld        (hold_vld_q),
    .fifo_full       (bus.fifo_full),
    .fifo_wr_success (bus.fifo_wr_success),
    .fifo_wr_en      (wr_en),
    .hold_release    (hold_release)
  );

  assign bus.fifo_wr_en  = wr_en;
  assign bus.word_out    = hold_q;
  assign bus.byte_toggle = byte_tgl_q;
  assign bus.word_toggle = word_tgl_q;
  assign bus.ovr_cnt     = ovr_cnt_q;
  assign bus.irq         = irq_q;

endmodule

// File: doc/rx_word_packer.md
RX_WORD_PACKER -- requirements
Module: rx_word_packer

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, bytes assembled per output word (legal 2..8).
REQ-002 SHALL have parameter ERR_CNT_W, default 16, width of parity-error and overrun counters.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = first byte lands in the top byte lane, 0 = first byte lands in lane 0.
REQ-004 SHALL have ports: s_axi_aclk in 1 (sole clock); s_axi_aresetn in 1 (synchronous, active-low reset).
REQ-005 SHALL have ports: data_in in 8 (received byte); data_valid in 1 (byte strobe, one cycle per byte); parity_in in 1 (received parity bit).
REQ-006 SHALL have ports: flush in 1 (discard partial word); clr_cnt in 1 (zero counters).
REQ-007 SHALL have ports: fifo_full in 1; fifo_wr_success in 1 (downstream write acknowledge); fifo_wr_en out 1; word_out out 8*BYTES_PER_WORD.
REQ-008 SHALL have ports: byte_toggle out 1; word_toggle out 1; par_err_cnt out ERR_CNT_W; ovr_cnt out ERR_CNT_W; irq out 1.

Function
REQ-009 SHALL hold a byte index 0..BYTES_PER_WORD-1, advanced on each data_valid and wrapped to 0 after the last byte.
REQ-010 SHALL write data_in into the lane selected by the index and MSB_FIRST on the cycle of data_valid.
REQ-011 SHALL invert byte_toggle on every accepted byte.
REQ-012 SHALL, on the last byte, copy the completed word, including the current data_in, into a one-entry holding register on the next clock and invert word_toggle.
REQ-013 SHALL, if the holding register is still occupied when a new word completes, drop the new word, increment ovr_cnt and leave the held word unchanged.
REQ-014 SHALL run a write FSM with states IDLE, WRITE and WAIT_ACK.
REQ-015 SHALL move IDLE->WRITE when the holding register is occupied and fifo_full=0; the word stays in the holding register while fifo_full=1.
REQ-016 SHALL assert fifo_wr_en for exactly one cycle in WRITE, with word_out stable from that cycle until the acknowledge, then move to WAIT_ACK.
REQ-017 SHALL, in WAIT_ACK, free the holding register and return to IDLE on fifo_wr_success=1; a fifo_wr_success seen in any other state SHALL be ignored.
REQ-018 SHALL, when flush=1, reset the byte index to 0 and discard the partial word, without affecting the holding register or the FSM.
REQ-019 SHALL, when flush and data_valid are high together, give flush priority: the byte is discarded and the index stays 0.
REQ-020 SHALL saturate both counters at all ones; clr_cnt=1 zeroes both counters, overriding any increment in the same cycle.
REQ-021 SHALL drive irq high for one cycle on each fifo_wr_success accepted in WAIT_ACK, and on each ovr_cnt increment.

Reset
REQ-022 SHALL, when s_axi_aresetn=0 on a clock edge, set index=0, FSM=IDLE, holding register empty, word_out=0, fifo_wr_en=0, irq=0, both toggles=0 and both counters=0.
REQ-023 SHALL abandon any partial word or pending write at reset; no fifo_wr_en follows release of reset until a new word completes.

Configuration
REQ-024 SHALL, with RX_PARITY_CHECK_EN defined, check even parity over {data_in, parity_in} on each accepted byte and increment par_err_cnt when the parity is odd; the byte is still packed.
REQ-025 SHALL, without RX_PARITY_CHECK_EN, contain no parity logic, tie par_err_cnt to 0 and ignore parity_in.

Structure
REQ-026 SHALL take the FSM state enum, the lane-index function and the default parameter constants from the shared package rx_pkg.
REQ-027 SHALL implement the IDLE/WRITE/WAIT_ACK handshake as the sub-module rx_fifo_wr_ctrl; packing and counters stay in the top level.

Verification
REQ-028 SHALL check: defaults, bytes 11,22,33,44 -> word_out=0x11223344, one fifo_wr_en pulse, word_toggle=1.
REQ-029 SHALL check: MSB_FIRST=0, same bytes -> word_out=0x44332211.
REQ-030 SHALL check: fifo_full=1 while a word completes -> no fifo_wr_en; fifo_full dropped -> exactly one pulse.
REQ-031 SHALL check: no fifo_wr_success, eight further bytes -> ovr_cnt=2, held word unchanged, irq pulses twice.
REQ-032 SHALL check: bytes AA,BB, then flush, then 01,02,03,04 -> word_out=0x01020304.
REQ-033 SHALL check: with RX_PARITY_CHECK_EN, data_in=0x01 with parity_in=0 -> par_err_cnt=1; same byte with parity_in=1 -> counter unchanged.
